// File: rtl/sine_voice_scheduler_if.sv
// Bus bundle for sine_voice_scheduler: sample tick, voice config port, sine pipeline
// handshake and mixed-sample outputs. The master side owns the timebase, the config
// writes and the shared sine pipeline; the slave side is the scheduler itself.
interface sine_voice_scheduler_if #(
  parameter int unsigned VOICE_W = 3
) ();
  logic               sample_tick;
  logic               cfg_we;
  logic [VOICE_W-1:0] cfg_voice;
  logic [15:0]        cfg_inc;
  logic               cfg_gate;
  logic [15:0]        sine_phase;
  logic [15:0]        sine_val;
  logic [15:0]        mix_out;
  logic               mix_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_gate, sine_val,
    input  sine_phase, mix_out, mix_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_gate, sine_val,
    output sine_phase, mix_out, mix_valid, busy, overrun
  );
endinterface

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one shared sine pipeline across NUM_VOICES phase-accumulator voices.
// Each sample tick issues every voice's phase in turn, collects the returned sine values
// into a signed accumulator and strobes out one mixed sample.
// Optional build macro SINE_VOICE_SCHED_SATURATE_EN: mix is the clipped sum instead of
// the average (accumulator >>> VOICE_W).
module sine_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VOICE_W    = 3,
  parameter int unsigned PIPE_LAT   = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  sine_voice_scheduler_if.slave bus
);

  localparam int unsigned ACC_W = 16 + VOICE_W;
  localparam int unsigned DW    = $clog2(PIPE_LAT) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                    state_q, state_d;
  logic [VOICE_W-1:0]        idx_q, idx_d;
  logic [DW-1:0]             drain_q, drain_d;
  logic                      issue, clear_acc, load_mix;

  logic [15:0]               phase_q [NUM_VOICES];
  logic [15:0]               phase_d [NUM_VOICES];
  logic [15:0]               inc_q   [NUM_VOICES];
  logic [15:0]               inc_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0]     gate_q, gate_d;

  logic [15:0]               sine_phase_q, sine_phase_d;
  // Entry 0 sits alongside sine_phase; entry PIPE_LAT lines up with the returned sine_val.
  logic [PIPE_LAT:0]         tag_valid_q, tag_valid_d;
  logic [PIPE_LAT:0]         tag_gate_q, tag_gate_d;

  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum, contrib;
  logic [15:0]               mix_q, mix_d, mix_res;
  logic                      mix_valid_q, mix_valid_d;
  logic                      overrun_q, overrun_d;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  // Frame sequencing: issue every voice, wait out the pipeline, then publish the mix.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    clear_acc = 1'b0;
    load_mix  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.sample_tick) begin
          state_d   = StIssue;
          idx_d     = '0;
          clear_acc = 1'b1;
        end
      end
      StIssue: begin
        issue = 1'b1;
        if (idx_q == VOICE_W'(NUM_VOICES - 1)) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DW'(PIPE_LAT - 1)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        load_mix = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Voice table, issue register, tag pipe, accumulator and output next-state.
  always_comb begin
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      phase_d[v] = phase_q[v];
      inc_d[v]   = inc_q[v];
      gate_d[v]  = gate_q[v];
      if (issue && idx_q == VOICE_W'(v) && gate_q[v]) begin
        phase_d[v] = phase_q[v] + inc_q[v];
      end
      // Config lands after the issue update so a gate-off clear beats the increment.
      if (bus.cfg_we && bus.cfg_voice == VOICE_W'(v)) begin
        inc_d[v]  = bus.cfg_inc;
        gate_d[v] = bus.cfg_gate;
        if (gate_q[v] && !bus.cfg_gate) begin
          phase_d[v] = '0;
        end
      end
    end

    sine_phase_d = issue ? phase_q[idx_q] : sine_phase_q;
    tag_valid_d  = {tag_valid_q[PIPE_LAT-1:0], issue};
    tag_gate_d   = {tag_gate_q[PIPE_LAT-1:0], gate_q[idx_q]};

    contrib = (tag_valid_q[PIPE_LAT] && tag_gate_q[PIPE_LAT]) ?
              {{VOICE_W{bus.sine_val[15]}}, bus.sine_val} : '0;
    acc_sum = acc_q + contrib;

    if (clear_acc) begin
      acc_d = '0;
    end else if (tag_valid_q[PIPE_LAT]) begin
      acc_d = acc_sum;
    end else begin
      acc_d = acc_q;
    end

`ifdef SINE_VOICE_SCHED_SATURATE_EN
    if (acc_sum[ACC_W-1:15] != {(ACC_W - 15){acc_sum[ACC_W-1]}}) begin
      mix_res = acc_sum[ACC_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      mix_res = acc_sum[15:0];
    end
`else
    mix_res = 16'(acc_sum >>> VOICE_W);
`endif

    // The last voice's sample arrives during DONE, so the mix uses acc_sum, not acc_q.
    mix_d       = load_mix ? mix_res : mix_q;
    mix_valid_d = load_mix;
    overrun_d   = overrun_q | (bus.sample_tick && state_q != StIdle);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
      end
      gate_q       <= '0;
      sine_phase_q <= '0;
      tag_valid_q  <= '0;
      tag_gate_q   <= '0;
      acc_q        <= '0;
      mix_q        <= '0;
      mix_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        phase_q[v] <= phase_d[v];
        inc_q[v]   <= inc_d[v];
      end
      gate_q       <= gate_d;
      sine_phase_q <= sine_phase_d;
      tag_valid_q  <= tag_valid_d;
      tag_gate_q   <= tag_gate_d;
      acc_q        <= acc_d;
      mix_q        <= mix_d;
      mix_valid_q  <= mix_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.sine_phase = sine_phase_q;
  assign bus.mix_out    = mix_q;
  assign bus.mix_valid  = mix_valid_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Self-checking bench for sine_voice_scheduler: models the shared sine pipeline as a
// fixed-latency lookup and predicts every frame from per-voice phase/inc/gate arrays.
module tb_sine_voice_scheduler;
  localparam int NV   = 8;
  localparam int VW   = 3;
  localparam int PLAT = 3;
  localparam int LAT  = NV + PLAT + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sine_voice_scheduler_if #(.VOICE_W(VW)) bus ();

  sine_voice_scheduler #(
    .NUM_VOICES(NV),
    .VOICE_W   (VW),
    .PIPE_LAT  (PLAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Sine pipeline stand-in: value is either a constant or a scramble of the phase.
  int          sine_mode = 0;
  logic [15:0] sine_const = 16'h0000;
  logic [15:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= bus.sine_phase;
    p2 <= p1;
    p3 <= p2;
  end
  always_comb bus.sine_val = (sine_mode == 0) ? sine_const : (p3 ^ 16'h3C3C);

  function automatic logic [15:0] sine_ref(input logic [15:0] p);
    return (sine_mode == 0) ? sine_const : (p ^ 16'h3C3C);
  endfunction

  // Reference voice state.
  logic [15:0] m_phase [NV];
  logic [15:0] m_inc   [NV];
  logic        m_gate  [NV];
  logic        m_ovr;
  logic [15:0] last_issued [NV];
  logic [15:0] last_mix;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_inc[v]   = '0;
      m_gate[v]  = 1'b0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic cfg_write(input int v, input logic [15:0] inc, input logic gate);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_voice = VW'(v);
    bus.cfg_inc   = inc;
    bus.cfg_gate  = gate;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    if (m_gate[v] && !gate) m_phase[v] = '0;
    m_inc[v]  = inc;
    m_gate[v] = gate;
  endtask

  // One frame; second_at > 0 raises another tick sampled that many edges after the first.
  task automatic run_frame(input string tag, input int second_at);
    logic [15:0]        exp_issued [NV];
    logic signed [15:0] s;
    int                 sum, first, pulses, busy_cnt;
    logic [15:0]        exp_mix, mix_seen;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      exp_issued[v] = m_phase[v];
      if (m_gate[v]) begin
        s = sine_ref(m_phase[v]);
        sum += int'(s);
        m_phase[v] = m_phase[v] + m_inc[v];
      end
    end
`ifdef SINE_VOICE_SCHED_SATURATE_EN
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    exp_mix = 16'(sum);
`else
    exp_mix = 16'(sum >>> VW);
`endif
    if (second_at >= 1 && second_at <= LAT - 1) m_ovr = 1'b1;

    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    first = 0;
    pulses = 0;
    mix_seen = '0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == second_at) bus.sample_tick = 1'b1;
      @(posedge clk);
      #1;
      bus.sample_tick = 1'b0;
      if (n <= NV) last_issued[n-1] = bus.sine_phase;
      if (bus.busy) busy_cnt++;
      if (bus.mix_valid) begin
        pulses++;
        if (first == 0) begin
          first = n + 1;
          mix_seen = bus.mix_out;
        end
      end
    end
    last_mix = mix_seen;
    check({tag, "_latency"}, 32'(first), 32'(LAT));
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT - 1));
    check({tag, "_mix"}, 32'(mix_seen), 32'(exp_mix));
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
    for (int v = 0; v < NV; v++) begin
      check($sformatf("%s_phase%0d", tag, v), 32'(last_issued[v]), 32'(exp_issued[v]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mix_out"}, 32'(bus.mix_out), 32'd0);
    check({tag, "_mix_valid"}, 32'(bus.mix_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    check({tag, "_sine_phase"}, 32'(bus.sine_phase), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_voice   = '0;
    bus.cfg_inc     = '0;
    bus.cfg_gate    = 1'b0;
    model_reset();

    // Reset held while inputs toggle.
    repeat (2) begin
      @(negedge clk);
      bus.sample_tick = 1'($urandom);
      bus.cfg_we      = 1'b1;
      bus.cfg_voice   = VW'($urandom);
      bus.cfg_inc     = 16'($urandom);
      bus.cfg_gate    = 1'b1;
    end
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    reset_n         = 1'b1;
    sine_mode       = 0;
    sine_const      = 16'h1234;
    run_frame("ungated", 0);

    // Voice 0 stepping and 16-bit wrap.
    cfg_write(0, 16'h1000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_frame("v0_step", 0);
      check("v0_step_const", 32'(last_issued[0]), 32'(i) * 32'h1000);
    end
    cfg_write(0, 16'hB000, 1'b1);
    run_frame("v0_to_f000", 0);
    cfg_write(0, 16'h2000, 1'b1);
    run_frame("v0_f000", 0);
    check("v0_f000_const", 32'(last_issued[0]), 32'h0000_F000);
    run_frame("v0_wrap", 0);
    check("v0_wrap_const", 32'(last_issued[0]), 32'h0000_1000);

    // All voices gated, constant sine values at the mix extremes.
    for (int v = 0; v < NV; v++) cfg_write(v, 16'($urandom), 1'b1);
    sine_const = 16'h4000;
    run_frame("all_pos", 0);
`ifdef SINE_VOICE_SCHED_SATURATE_EN
    check("all_pos_const", 32'(last_mix), 32'h0000_7FFF);
`else
    check("all_pos_const", 32'(last_mix), 32'h0000_4000);
`endif
    sine_const = 16'hC000;
    run_frame("all_neg", 0);
`ifdef SINE_VOICE_SCHED_SATURATE_EN
    check("all_neg_const", 32'(last_mix), 32'h0000_8000);
`else
    check("all_neg_const", 32'(last_mix), 32'h0000_C000);
`endif

    // Tick while busy.
    run_frame("overrun", 5);
    run_frame("post_overrun", 0);

    // Voice 2 gate off clears its phase.
    sine_mode = 1;
    cfg_write(2, 16'h0100, 1'b0);
    cfg_write(2, 16'h0100, 1'b1);
    for (int i = 0; i < 3; i++) run_frame("v2_run", 0);
    cfg_write(2, 16'h0100, 1'b0);
    run_frame("v2_off", 0);
    cfg_write(2, 16'h0100, 1'b1);
    run_frame("v2_on", 0);
    check("v2_restart_const", 32'(last_issued[2]), 32'd0);

    // Randomized config and sine content.
    for (int f = 0; f < 16; f++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        cfg_write(int'($urandom_range(0, NV - 1)), 16'($urandom), 1'($urandom));
      end
      sine_mode  = int'($urandom_range(0, 1));
      sine_const = 16'($urandom);
      run_frame($sformatf("rand%0d", f), 0);
    end

    // Reset in the middle of a frame.
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.mix_valid) pulses++;
    end
    check("midreset_no_valid", 32'(pulses), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    sine_mode  = 0;
    sine_const = 16'h0777;
    run_frame("after_reset", 0);
    cfg_write(5, 16'h0040, 1'b1);
    run_frame("after_reset_v5", 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sine_voice_scheduler.md
Name: sine_voice_scheduler

Overview:
Time-multiplexes one shared quarter-wave sine pipeline (3-cycle latency) across NUM_VOICES oscillator voices. On each sample tick it advances every voice's 16-bit phase accumulator and issues each phase to the sine pipeline in turn. It then collects the returned sine values, mixes them into one 16-bit sample and strobes it out. It sits between the sample-rate timebase and the audio output path, with a simple config port for per-voice increment and gate.

Parameters:
NUM_VOICES, 8, number of voices; power of two, 2..16
VOICE_W, 3, log2(NUM_VOICES); voice index width
PIPE_LAT, 3, sine pipeline latency in cycles from sine_phase presented to matching sine_val

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle pulse requesting a new output sample
cfg_we  in  1  config write strobe
cfg_voice  in  VOICE_W  voice index for config write
cfg_inc  in  16  phase increment for cfg_voice
cfg_gate  in  1  voice enable for cfg_voice
sine_phase  out  16  registered phase to the sine pipeline
sine_val  in  16  signed sine value returned PIPE_LAT cycles after the matching sine_phase
mix_out  out  16  signed mixed sample, held until next frame
mix_valid  out  1  one-cycle strobe, mix_out updated
busy  out  1  high while a frame is in progress (state != IDLE)
overrun  out  1  sticky; sample_tick arrived while busy

Behaviour:
- Reset (async, reset_n=0):
  - All outputs go to 0: sine_phase, mix_out, mix_valid, busy, overrun.
  - All phase accumulators, increments, gates, tag pipe and accumulator clear.
  - State goes to IDLE.
- FSM:
  - IDLE: on sample_tick=1, go to ISSUE with idx=0 and clear the accumulator.
  - ISSUE: one voice per cycle, idx 0..NUM_VOICES-1. After the last voice, go to DRAIN.
  - DRAIN: PIPE_LAT cycles, then go to DONE.
  - DONE: one cycle; mix_out loads, mix_valid=1, then return to IDLE.
- ISSUE per-cycle action for voice idx:
  - sine_phase <= phase[idx], the pre-increment value.
  - If gate[idx]=1: phase[idx] <= phase[idx]+inc[idx], mod 2^16 (e.g. 0xF000+0x2000 -> 0x1000).
  - Push tag {valid=1, gate[idx]} into a PIPE_LAT-deep shift register.
- Collection: whenever the tag at the shift-register output is valid, add sine_val to the signed accumulator (16+VOICE_W bits) if its gate bit is 1, else add 0.
- Ungated voices: still occupy an issue slot, so frame timing is constant.
- Latency: mix_valid pulses exactly NUM_VOICES+PIPE_LAT+2 cycles after the edge that sampled sample_tick (13 cycles for defaults). busy is high from the cycle after the tick through the DONE cycle.
- Mix rule (default): mix_out = accumulator >>> VOICE_W (arithmetic shift), i.e. the average of all slots.
- sample_tick while busy: ignored, the frame is not restarted, and overrun is set to 1. overrun clears only on reset.
- Config writes are accepted in any state and take effect at the next edge:
  - inc[cfg_voice] <= cfg_inc.
  - gate[cfg_voice] <= cfg_gate.
  - A gate transition 1->0 also clears phase[cfg_voice] to 0.
- Config write to the voice being issued in the same cycle: issue and phase update use the old inc/gate; the write then lands. If the write clears the gate, the phase clear wins over the increment.
- Reset mid-frame: frame aborted, no mix_valid, all state cleared.

Optional Feature:
SINE_VOICE_SCHED_SATURATE_EN
- Defined: mix_out = accumulator clipped to [-32768, 32767] (sum with no averaging shift).
- Undefined: arithmetic shift by VOICE_W as above.
- Timing, latency and all other behaviour are identical either way.

Test Plan:
1. Reset with reset_n=0 for 2 cycles while toggling inputs -> mix_out=0, mix_valid=0, busy=0, overrun=0, sine_phase=0. Then release reset, send tick -> mix_valid after 13 cycles with mix_out=0 (all voices ungated).
2. Voice 0 inc=0x1000, gate=1, 4 ticks -> sine_phase in voice-0 slot = 0x0000, 0x1000, 0x2000, 0x3000. Separately, with voice 0 phase=0xF000 and inc=0x2000 -> next issued phase 0x1000.
3. All 8 voices gated, bench pipeline model returns 0x4000 -> default build mix_out=0x4000; SATURATE_EN build mix_out=0x7FFF. Model returns 0xC000 -> default 0xC000, saturated 0x8000.
4. sample_tick 5 cycles after a tick -> overrun=1, exactly one mix_valid, at cycle 13 after the first tick. Subsequent idle tick -> normal frame, overrun stays 1.
5. Voice 2 gated with inc=0x0100 for 3 frames (phase 0x0300), then gate=0, then gate=1 -> next issued phase for voice 2 = 0x0000. Sum excludes voice 2 while ungated.
6. Assert reset_n at cycle 6 of a frame -> immediate reset values, no mix_valid. Next tick -> normal 13-cycle frame.
